alu_issue_ctrl: RTL

Controller that shares the 16-bit ALU between two requesters and sequences each operation through issue, wait and response phases. Owns the architectural accumulator (ACC) used by the write-to-A opcodes. Sits between the requesting units and the registered ALU datapath, and drives the ALU's opcode and operand inputs.

---
 rtl/alu_issue_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
//
// Shares one registered 16-bit ALU between two requesters. Each accepted
// operation is sequenced IDLE -> ISSUE -> WAIT (ALU_LATENCY cycles) -> RESP,
// with at most one operation outstanding. The block also owns the
// architectural accumulator (ACC): opcodes 101..111 read ACC as operand A and
// write the ALU result back into it. A NOP never reaches the ALU and simply
// returns the current ACC.
//
// Ports
//   CLK, RST          clock (rising edge), asynchronous active-low reset
//   Enable            1 = new grants allowed; an in-flight op always completes
//   req_valid/ready   per-requester handshake (bit i = requester i)
//   req_op/a/b        per-requester opcode (3 bits) and operands (DATA_W each)
//   rsp_valid/ready   response handshake; rsp_id/data/cf held while stalled
//   alu_en            one-cycle issue strobe to the ALU
//   alu_op/a/b        ALU opcode and operands (held through WAIT)
//   alu_result/cf     ALU outputs, valid ALU_LATENCY cycles after issue
//   acc_out           current ACC value
// -----------------------------------------------------------------------------
module alu_issue_ctrl #(
    parameter int DATA_W      = 16,
    parameter int ALU_LATENCY = 1    // legal range 1..7
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                Enable,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [5:0]          req_op,
    input  logic [2*DATA_W-1:0] req_a,
    input  logic [2*DATA_W-1:0] req_b,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_id,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                rsp_cf,
    output logic                alu_en,
    output logic [2:0]          alu_op,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    input  logic [DATA_W-1:0]   alu_result,
    input  logic                alu_cf,
    output logic [DATA_W-1:0]   acc_out
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

    localparam logic [2:0]       OP_NOP    = 3'b000;
    localparam int               CNT_W     = 3;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(ALU_LATENCY - 1);

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  acc_q, acc_d;
    logic [DATA_W-1:0]  a_q, a_d;
    logic [DATA_W-1:0]  b_q, b_d;
    logic [2:0]         op_q, op_d;
    logic               id_q, id_d;
    logic               rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
    logic               rsp_cf_q, rsp_cf_d;

    logic               grant_ok;
    logic               grant_id;
    logic [2:0]         sel_op;
    logic [DATA_W-1:0]  sel_a;
    logic [DATA_W-1:0]  sel_b;

    // Opcodes 101, 110, 111 take ACC as operand A and write the result back.
    function automatic logic is_wb(input logic [2:0] op);
        return op[2] & (op[1] | op[0]);
    endfunction

    // Arbitration: contention goes to rr_ptr, a lone requester always wins.
    // Grants are also gated by RST so req_ready reads 0 while reset is held.
    always_comb begin
        grant_ok = RST & Enable & (state_q == S_IDLE) & (|req_valid);
        grant_id = (&req_valid) ? rr_ptr_q : req_valid[1];
        sel_op   = grant_id ? req_op[5:3]             : req_op[2:0];
        sel_a    = grant_id ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
        sel_b    = grant_id ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0];
    end

    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        id_d       = id_q;
        rr_ptr_d   = rr_ptr_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_cf_d   = rsp_cf_q;
        req_ready  = '0;

        unique case (state_q)
            S_IDLE: begin
                if (grant_ok) begin
                    req_ready[grant_id] = 1'b1;
                    op_d     = sel_op;
                    // ACC cannot change before issue, so it is latched here.
                    a_d      = is_wb(sel_op) ? acc_q : sel_a;
                    b_d      = sel_b;
                    id_d     = grant_id;
                    rr_ptr_d = ~grant_id;
                    if (sel_op == OP_NOP) begin
                        rsp_data_d = acc_q;
                        rsp_cf_d   = 1'b0;
                        state_d    = S_RESP;
                    end else begin
                        state_d    = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                cnt_d   = WAIT_LAST;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    rsp_data_d = alu_result;
                    rsp_cf_d   = alu_cf;
                    if (is_wb(op_q)) begin
                        acc_d = alu_result;
                    end
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= OP_NOP;
            id_q       <= 1'b0;
            rr_ptr_q   <= 1'b0;
            cnt_q      <= '0;
            rsp_data_q <= '0;
            rsp_cf_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            id_q       <= id_d;
            rr_ptr_q   <= rr_ptr_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_cf_q   <= rsp_cf_d;
        end
    end

    // ALU operand outputs follow the latched operation; they are stable from
    // ISSUE through the end of WAIT.
    assign alu_en    = (state_q == S_ISSUE);
    assign alu_op    = op_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_id    = id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_cf    = rsp_cf_q;
    assign acc_out   = acc_q;

endmodule
